// File: rtl/div_pkg.sv
// Shared types and constants for the reciprocal / reciprocal-square-root sequencer.
package div_pkg;

   typedef enum logic [2:0] {
      OP_RCP  = 3'd0,
      OP_RCPL = 3'd1,
      OP_RCPH = 3'd2,
      OP_RSQ  = 3'd3,
      OP_RSQL = 3'd4,
      OP_RSQH = 3'd5,
      OP_MOV  = 3'd6
   } div_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NORM = 2'd1,
      ST_ROM  = 2'd2,
      ST_DONE = 2'd3
   } div_state_e;

   localparam logic [31:0] DIV_ZERO_RES = 32'h7FFF_FFFF;
   localparam logic [31:0] DIV_MIN_RES  = 32'hFFFF_0000;

   function automatic logic op_is_rom(input div_op_e op);
      return (op == OP_RCP) || (op == OP_RCPL) || (op == OP_RSQ) || (op == OP_RSQL);
   endfunction

   function automatic logic op_is_h(input div_op_e op);
      return (op == OP_RCPH) || (op == OP_RSQH);
   endfunction

   function automatic logic op_is_l(input div_op_e op);
      return (op == OP_RCPL) || (op == OP_RSQL);
   endfunction

   function automatic logic op_is_rsq(input div_op_e op);
      return (op == OP_RSQ) || (op == OP_RSQL) || (op == OP_RSQH);
   endfunction

endpackage

// File: rtl/div_norm.sv
// Operand normalizer: magnitude, leading-zero count and ROM address.
module div_norm
   import div_pkg::*;
#(
   parameter int ROM_AW = 10
) (
   input  logic [31:0]       opnd_i,
   input  logic              rsq_i,
   output logic [4:0]        shift_o,
   output logic [ROM_AW-1:0] addr_o
);

   logic [31:0] abs_val;
   logic [8:0]  idx;

   always_comb begin
      abs_val = opnd_i[31] ? (~opnd_i + 32'd1) : opnd_i;
      // Highest set bit wins; an all-zero magnitude saturates to 31.
      shift_o = 5'd31;
      for (int b = 0; b < 32; b++) begin
         if (abs_val[b]) shift_o = 5'(31 - b);
      end
      idx = 9'((abs_val << shift_o) >> 22);
      addr_o = '0;
      addr_o[ROM_AW-1] = rsq_i;
      addr_o[8:0] = rsq_i ? {idx[8:1], shift_o[0]} : idx;
   end

endmodule

// File: rtl/div_ctl.sv
// Reciprocal / rsqrt ROM sequencer with double-precision H/L state.
// DIV_RSQ_EN: compiles in the RSQ table path; otherwise RSQ ops run as RCP.
module div_ctl
   import div_pkg::*;
#(
   parameter int ROM_AW = 10,
   parameter int ROM_DW = 16
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              Stall,
   input  logic              DivReq,
   input  logic [2:0]        DivOp,
   input  logic [15:0]       DivSrc,
   output logic              DivBusy,
   output logic              RunClk,
   output logic [ROM_AW-1:0] RomAddr,
   input  logic [ROM_DW-1:0] RomData,
   output logic              DivOutVld,
   output logic [15:0]       DivOut
);

   div_state_e  state_q, state_d;
   div_op_e     op_q;
   div_op_e     op_in;
   logic [15:0] src_q, in_hi_q, out_hi_q, out_q;
   logic        dpend_q;
   logic        run_clk, accept, rsq;
   logic [31:0] opnd, rom_mant, rom_res;
   logic [4:0]  shift, rsh;

   assign op_in  = div_op_e'(DivOp);
   assign accept = (state_q == ST_IDLE) && DivReq && !Stall;

`ifdef DIV_RSQ_EN
   assign rsq = op_is_rsq(op_q);
`else
   assign rsq = 1'b0;
`endif

   // An L op only pairs with a pending H; otherwise it is single precision.
   assign opnd = (op_is_l(op_q) && dpend_q) ? {in_hi_q, src_q} : {{16{src_q[15]}}, src_q};

   div_norm #(.ROM_AW(ROM_AW)) u_norm (
      .opnd_i  (opnd),
      .rsq_i   (rsq),
      .shift_o (shift),
      .addr_o  (RomAddr)
   );

   always_comb begin
      rom_mant = 32'({1'b1, RomData}) << (30 - ROM_DW);
      rsh      = 5'd31 - shift;
      if (rsq) rsh = rsh >> 1;
      rom_res  = rom_mant >> rsh;
      if (opnd[31]) rom_res = ~rom_res;
      if (opnd == 32'd0)             rom_res = DIV_ZERO_RES;
      else if (opnd == 32'h8000_0000) rom_res = DIV_MIN_RES;
   end

   always_comb begin
      state_d = state_q;
      run_clk = 1'b0;
      if (!Stall) begin
         case (state_q)
            ST_IDLE: if (DivReq) state_d = op_is_rom(op_in) ? ST_NORM : ST_DONE;
            ST_NORM: begin
               state_d = ST_ROM;
               run_clk = 1'b1;
            end
            ST_ROM:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         op_q     <= OP_RCP;
         src_q    <= '0;
         in_hi_q  <= '0;
         out_hi_q <= '0;
         out_q    <= '0;
         dpend_q  <= 1'b0;
      end else if (accept) begin
         op_q  <= op_in;
         src_q <= DivSrc;
         if (op_is_h(op_in)) begin
            in_hi_q <= DivSrc;
            dpend_q <= 1'b1;
            out_q   <= out_hi_q;
         end else if (!op_is_rom(op_in)) begin
            out_q <= DivSrc;
         end
      end else if ((state_q == ST_ROM) && !Stall) begin
         out_q    <= rom_res[15:0];
         out_hi_q <= rom_res[31:16];
         dpend_q  <= 1'b0;
      end
   end

   assign DivBusy   = (state_q != ST_IDLE);
   assign DivOutVld = (state_q == ST_DONE);
   assign RunClk    = run_clk;
   assign DivOut    = out_q;

endmodule

// File: tb/tb_div_ctl.sv
// Scoreboard bench for div_ctl: model predicts each result, monitor checks it on DivOutVld.
`timescale 1ns/1ps
module tb_div_ctl;
   import div_pkg::*;

   logic        CLK = 1'b0;
   logic        Reset, Stall, DivReq;
   logic [2:0]  DivOp;
   logic [15:0] DivSrc;
   logic        DivBusy, RunClk, DivOutVld;
   logic [9:0]  RomAddr;
   logic [15:0] RomData;
   logic [15:0] DivOut;

   int n_run  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      logic [15:0] out;
      int          req_cyc;
      int          lat;
      int          rc_off;
      int          nrc;
      logic [9:0]  addr;
   } exp_t;
   exp_t exp_q[$];

   logic [15:0] m_in_hi  = 16'h0;
   logic [15:0] m_out_hi = 16'h0;
   logic        m_dpend  = 1'b0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   div_ctl #(.ROM_AW(10), .ROM_DW(16)) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .Stall     (Stall),
      .DivReq    (DivReq),
      .DivOp     (DivOp),
      .DivSrc    (DivSrc),
      .DivBusy   (DivBusy),
      .RunClk    (RunClk),
      .RomAddr   (RomAddr),
      .RomData   (RomData),
      .DivOutVld (DivOutVld),
      .DivOut    (DivOut)
   );

   function automatic logic [15:0] rom_word(input logic [9:0] a);
      logic [15:0] w;
      w = {a[5:0], a} ^ 16'h3C5A;
      return (a == 10'd0) ? 16'hFFFF : w;
   endfunction

   // Synchronous ROM: word appears the cycle after the RunClk request.
   always @(posedge CLK) if (RunClk) RomData <= rom_word(RomAddr);

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic void model_lookup(input logic [31:0] opnd, input logic rsq,
                                        output logic [9:0] addr, output logic [31:0] res);
      logic [31:0] a, n, m;
      logic [8:0]  idx;
      logic [4:0]  sh5;
      int sh;
      a  = opnd[31] ? (32'd0 - opnd) : opnd;
      sh = 31;
      for (int b = 31; b >= 0; b--) if (a[b]) begin sh = 31 - b; break; end
      sh5 = 5'(sh);
      n   = a << sh;
      idx = n[30:22];
      addr = rsq ? {1'b1, idx[8:1], sh5[0]} : {1'b0, idx};
      m   = {15'd0, 1'b1, rom_word(addr)} << 14;
      res = rsq ? (m >> ((31 - sh) / 2)) : (m >> (31 - sh));
      if (opnd[31]) res = ~res;
      if (opnd == 32'h0000_0000) res = 32'h7FFF_FFFF;
      if (opnd == 32'h8000_0000) res = 32'hFFFF_0000;
   endfunction

   // Called at posedge+#1; returns at posedge+#1 after the accepting edge (plus stall).
   task automatic issue(input div_op_e op, input logic [15:0] src, input int nstall);
      exp_t e;
      logic [31:0] opnd, res;
      logic [9:0]  addr;
      logic        rsq;
      int t;
      t = 0;
      while (DivBusy && t < 20) begin @(posedge CLK); #1; t++; end
      check_val("busy_timeout", 32'(DivBusy), 32'd0);
      rsq = 1'b0;
`ifdef DIV_RSQ_EN
      rsq = (op == OP_RSQ) || (op == OP_RSQL) || (op == OP_RSQH);
`endif
      e.addr = 10'd0; e.nrc = 0; e.rc_off = 0; e.lat = 1;
      case (op)
         OP_RCPH, OP_RSQH: begin
            e.out = m_out_hi; m_in_hi = src; m_dpend = 1'b1;
         end
         OP_MOV: e.out = src;
         default: begin
            opnd = ((op == OP_RCPL || op == OP_RSQL) && m_dpend) ? {m_in_hi, src}
                                                                 : {{16{src[15]}}, src};
            model_lookup(opnd, rsq, addr, res);
            e.out = res[15:0]; e.addr = addr; m_out_hi = res[31:16]; m_dpend = 1'b0;
            e.lat = 3 + nstall; e.rc_off = 1 + nstall; e.nrc = 1;
         end
      endcase
      DivOp = op; DivSrc = src; DivReq = 1'b1;
      e.req_cyc = cyc;
      exp_q.push_back(e);
      @(posedge CLK); #1;
      DivReq = 1'b0; DivSrc = 16'($urandom); DivOp = 3'($urandom_range(0, 6));
      if (nstall > 0) begin
         Stall = 1'b1;
         repeat (nstall) @(posedge CLK);
         #1;
         Stall = 1'b0;
      end
   endtask

   int          rc_cnt    = 0;
   logic        prev_rc   = 1'b0;
   logic [9:0]  prev_addr = 10'd0;

   always @(negedge CLK) begin
      exp_t e;
      if (Reset) begin
         rc_cnt = 0; prev_rc = 1'b0;
      end else begin
         if (prev_rc) check_val("addr_hold", 32'(RomAddr), 32'(prev_addr));
         if (RunClk) begin
            check_val("runclk_in_stall", 32'(Stall), 32'd0);
            if (exp_q.size() > 0) begin
               check_val("rom_addr", 32'(RomAddr), 32'(exp_q[0].addr));
               check_val("runclk_cyc", 32'(cyc - exp_q[0].req_cyc), 32'(exp_q[0].rc_off));
            end
            rc_cnt++;
         end
         prev_rc = RunClk; prev_addr = RomAddr;
         if (DivOutVld) begin
            if (exp_q.size() == 0) check_val("spurious_vld", 32'(DivOutVld), 32'd0);
            else begin
               e = exp_q.pop_front();
               check_val("div_out", 32'(DivOut), 32'(e.out));
               check_val("latency", 32'(cyc - e.req_cyc), 32'(e.lat));
               check_val("runclk_cnt", 32'(rc_cnt), 32'(e.nrc));
               $display("[TB] cyc %0d out=%04h exp=%04h lat=%0d", cyc, DivOut, e.out, cyc - e.req_cyc);
            end
            rc_cnt = 0;
         end
      end
   end

   initial begin
      div_op_e op;
      int t;
      Reset = 1'b1; Stall = 1'b0; DivReq = 1'b0; DivOp = 3'd0; DivSrc = 16'h0;
      repeat (3) @(posedge CLK);
      #1;
      check_val("rst_busy", 32'(DivBusy), 32'd0);
      check_val("rst_runclk", 32'(RunClk), 32'd0);
      check_val("rst_addr", 32'(RomAddr), 32'd0);
      check_val("rst_vld", 32'(DivOutVld), 32'd0);
      check_val("rst_out", 32'(DivOut), 32'd0);
      Reset = 1'b0;
      @(posedge CLK); #1;

      issue(OP_RCPH, 16'h0000, 0);               // reset DivOutHi
      issue(OP_RCP,  16'h0001, 0);               // C000
      issue(OP_RCPH, 16'hAAAA, 0);               // 7FFF
      issue(OP_RCP,  16'h0000, 0);               // zero operand
      issue(OP_RCPH, 16'h0000, 0);
      issue(OP_RCPH, 16'h0001, 0);
      issue(OP_RCPL, 16'h0000, 0);               // operand 0001_0000
      issue(OP_RCPH, 16'h0005, 0);               // high half of that result
      issue(OP_RCPL, 16'h0000, 0);
      issue(OP_RCPL, 16'h0000, 0);               // pending cleared -> zero operand
      issue(OP_RSQ,  16'h0004, 0);
      issue(OP_RSQL, 16'hFFF3, 0);
      issue(OP_RCP,  16'h0123, 2);               // stall in NORM
      issue(OP_RCPH, 16'h8000, 0);
      issue(OP_RCPL, 16'h0000, 0);               // 8000_0000
      issue(OP_RCPH, 16'h0000, 0);
      issue(OP_RCP,  16'h8000, 0);               // FFFF_8000
      issue(OP_MOV,  16'hBEEF, 0);
      issue(OP_RCPH, 16'h0002, 0);
      issue(OP_MOV,  16'h0001, 0);               // MOV keeps the pending H
      issue(OP_RCPL, 16'h0003, 0);
      issue(OP_RCPH, 16'h0007, 0);
      issue(OP_RCPH, 16'h0009, 0);               // second H overwrites
      issue(OP_RSQL, 16'h0001, 0);

      // Requests while busy must be ignored.
      issue(OP_RCP, 16'h0040, 0);
      DivReq = 1'b1; DivOp = 3'(OP_MOV); DivSrc = 16'h5555;
      repeat (2) @(posedge CLK);
      #1;
      DivReq = 1'b0;

      for (int i = 0; i < 24; i++) begin
         op = div_op_e'(3'($urandom_range(0, 6)));
         issue(op, 16'($urandom), op_is_rom(op) ? int'($urandom_range(0, 2)) : 0);
      end

      // Reset while in the ROM state.
      issue(OP_RCPH, 16'h1234, 0);
      issue(OP_RCPL, 16'h0005, 0);
      @(posedge CLK); #1;
      Reset = 1'b1;
      @(posedge CLK); #1;
      Reset = 1'b0;
      exp_q.delete();
      m_dpend = 1'b0; m_in_hi = 16'h0; m_out_hi = 16'h0;
      check_val("abort_busy", 32'(DivBusy), 32'd0);
      check_val("abort_vld", 32'(DivOutVld), 32'd0);
      repeat (3) @(posedge CLK);
      #1;
      issue(OP_RCPL, 16'h0000, 0);               // pending was cleared by reset
      issue(OP_RCPH, 16'h0000, 0);

      t = 0;
      while ((exp_q.size() > 0 || DivBusy) && t < 50) begin @(posedge CLK); #1; t++; end
      check_val("drain", 32'(exp_q.size()), 32'd0);
      repeat (3) @(posedge CLK);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
